// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes, control-word bit positions and sequencer states.
// Both the sequencer and the datapath register unit decode the cs bus with these indices.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CS_IDLE   = 0;
    localparam int CS_LOAD   = 1;
    localparam int CS_ADD    = 2;
    localparam int CS_SUB    = 3;
    localparam int CS_SHIFT  = 4;
    localparam int CS_RESULT = 5;
    localparam int CS_COUNT  = 6;
    localparam int CS_FIX    = 7;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_ADDSUB = 4'd2,
        S_EXAM   = 4'd3,
        S_MSHIFT = 4'd4,
        S_DSHIFT = 4'd5,
        S_DARITH = 4'd6,
        S_FIX    = 4'd7,
        S_RESULT = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    function automatic logic [7:0] cs_bit(input int idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Control/status bundle between the ALU sequencer (master) and the datapath register unit (slave).
// start is a level held by the datapath until it sees stop; stop is a one-cycle pulse.
interface alu_sequencer_if;

    logic       start;
    logic [1:0] opcode;
    logic       q0;
    logic       q_1;
    logic       a_msb;
    logic [7:0] cs;
    logic       stop;
    logic       busy;

    modport master (
        input  start, opcode, q0, q_1, a_msb,
        output cs, stop, busy
    );

    modport slave (
        output start, opcode, q0, q_1, a_msb,
        input  cs, stop, busy
    );

endinterface

// File: rtl/alu_iter_counter.sv
// Iteration counter for the multiply/divide loops; last flags count == WIDTH-1.
// Saturates at WIDTH-1 so it only ever wraps through the clear.
module alu_iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] count;

    assign last = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control FSM for the ALU datapath: add/sub in 4 cycles, Booth multiply and non-restoring
// divide in 2*WIDTH+3 cycles (+1 for remainder fix); no backpressure, stop pulses once per op.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    alu_sequencer_if.master    bus
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op_r;
    logic       sgn_r;
    logic       fin_r;
    logic       last;
    logic [7:0] cs;
    logic       stop;

    alu_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_LOAD),
        .inc  ((state == S_MSHIFT) || (state == S_DSHIFT)),
        .last (last)
    );

    // fin_r marks the final divide iteration, since the counter saturates at WIDTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_r  <= OP_ADD;
            sgn_r <= 1'b0;
            fin_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) op_r <= bus.opcode;
            if (state == S_LOAD) fin_r <= 1'b0;
            if (state == S_DSHIFT) begin
                sgn_r <= bus.a_msb;
                fin_r <= last;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LOAD;
            S_LOAD: begin
                unique case (op_r)
                    OP_ADD, OP_SUB: state_nxt = S_ADDSUB;
                    OP_MUL:         state_nxt = S_EXAM;
                    OP_DIV:         state_nxt = S_DSHIFT;
                    default:        state_nxt = S_ADDSUB;
                endcase
            end
            S_ADDSUB: state_nxt = S_RESULT;
            S_EXAM:   state_nxt = S_MSHIFT;
            S_MSHIFT: state_nxt = last ? S_RESULT : S_EXAM;
            S_DSHIFT: state_nxt = S_DARITH;
            S_DARITH: begin
                if (!fin_r)         state_nxt = S_DSHIFT;
                else if (bus.a_msb) state_nxt = S_FIX;
                else                state_nxt = S_RESULT;
            end
            S_FIX:    state_nxt = S_RESULT;
            S_RESULT: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cs   = '0;
        stop = 1'b0;
        unique case (state)
            S_IDLE:   cs = cs_bit(CS_IDLE);
            S_LOAD:   cs = cs_bit(CS_LOAD);
            S_ADDSUB: cs = (op_r == OP_SUB) ? cs_bit(CS_SUB) : cs_bit(CS_ADD);
            S_EXAM: begin
                // Booth recoding: 01 adds the multiplicand, 10 subtracts it.
                unique case ({bus.q0, bus.q_1})
                    2'b01:   cs = cs_bit(CS_ADD);
                    2'b10:   cs = cs_bit(CS_SUB);
                    default: cs = '0;
                endcase
            end
            S_MSHIFT, S_DSHIFT: cs = cs_bit(CS_SHIFT) | cs_bit(CS_COUNT);
            S_DARITH: cs = sgn_r ? cs_bit(CS_ADD) : cs_bit(CS_SUB);
            S_FIX:    cs = cs_bit(CS_FIX);
            S_RESULT: cs = cs_bit(CS_RESULT);
            S_DONE:   stop = 1'b1;
            default:  cs = cs_bit(CS_IDLE);
        endcase
    end

    assign bus.cs   = cs;
    assign bus.stop = stop;
    assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with hand-computed per-cycle expectations.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        int         tid;
        logic       start;
        logic [1:0] op;
        logic       q0;
        logic       q_1;
        logic       a_msb;
        logic [7:0] cs;
        logic       stop;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add_vec(input int tid, input logic st, input logic [1:0] op,
                           input logic q0, input logic q_1, input logic am,
                           input logic [7:0] cs, input logic stp, input logic bsy);
        vec_t v;
        v.tid = tid; v.start = st; v.op = op; v.q0 = q0; v.q_1 = q_1; v.a_msb = am;
        v.cs = cs; v.stop = stp; v.busy = bsy;
        tbl.push_back(v);
    endtask

    task automatic check(input int tid, input int idx, input logic [7:0] cs,
                         input logic stp, input logic bsy);
        n_vec++;
        if (bus.cs !== cs || bus.stop !== stp || bus.busy !== bsy) begin
            n_bad++;
            $display("FAIL test%0d cycle%0d: got cs=%h stop=%b busy=%b, expected cs=%h stop=%b busy=%b",
                     tid, idx, bus.cs, bus.stop, bus.busy, cs, stp, bsy);
        end
    endtask

    // One cycle: drive inputs just after the edge, compare just after that.
    task automatic step(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        bus.start = v.start; bus.opcode = v.op;
        bus.q0 = v.q0; bus.q_1 = v.q_1; bus.a_msb = v.a_msb;
        #1;
        check(v.tid, idx, v.cs, v.stop, v.busy);
    endtask

    task automatic mk_addsub(input int tid, input logic [1:0] op, input logic [1:0] flip_op,
                             input logic [7:0] arith_cs);
        add_vec(tid, 1, op,      0, 0, 0, 8'h01, 0, 0);
        add_vec(tid, 1, op,      0, 0, 0, 8'h02, 0, 1);
        add_vec(tid, 1, flip_op, 0, 0, 0, arith_cs, 0, 1);
        add_vec(tid, 1, flip_op, 0, 0, 0, 8'h20, 0, 1);
        add_vec(tid, 1, flip_op, 0, 0, 0, 8'h00, 1, 1);
        add_vec(tid, 0, flip_op, 0, 0, 0, 8'h01, 0, 0);
    endtask

    task automatic mk_mul(input int tid);
        add_vec(tid, 1, 2'b10, 0, 0, 0, 8'h01, 0, 0);
        add_vec(tid, 1, 2'b10, 0, 0, 0, 8'h02, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 1)      add_vec(tid, 1, 2'b10, 1, 0, 0, 8'h08, 0, 1);
            else if (i == 2) add_vec(tid, 1, 2'b10, 0, 1, 0, 8'h04, 0, 1);
            else             add_vec(tid, 1, 2'b10, 0, 0, 0, 8'h00, 0, 1);
            add_vec(tid, 1, 2'b10, 0, 0, 0, 8'h50, 0, 1);
        end
        add_vec(tid, 1, 2'b10, 0, 0, 0, 8'h20, 0, 1);
        add_vec(tid, 1, 2'b10, 0, 0, 0, 8'h00, 1, 1);
        add_vec(tid, 0, 2'b10, 0, 0, 0, 8'h01, 0, 0);
    endtask

    task automatic mk_div(input int tid, input logic final_msb);
        add_vec(tid, 1, 2'b11, 0, 0, 0, 8'h01, 0, 0);
        add_vec(tid, 1, 2'b11, 0, 0, 0, 8'h02, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            add_vec(tid, 1, 2'b11, 0, 0, (i == 3), 8'h50, 0, 1);
            add_vec(tid, 1, 2'b11, 0, 0, (i == 8) ? final_msb : 1'b0,
                    (i == 3) ? 8'h04 : 8'h08, 0, 1);
        end
        if (final_msb) add_vec(tid, 1, 2'b11, 0, 0, 0, 8'h80, 0, 1);
        add_vec(tid, 1, 2'b11, 0, 0, 0, 8'h20, 0, 1);
        add_vec(tid, 1, 2'b11, 0, 0, 0, 8'h00, 1, 1);
        add_vec(tid, 0, 2'b11, 0, 0, 0, 8'h01, 0, 0);
    endtask

    initial begin
        vec_t v;

        // Vector table: each sequence starts and ends in IDLE with start low.
        mk_mul(1);                          // also proves restart at LOAD after reset
        mk_addsub(2, 2'b00, 2'b00, 8'h04);
        mk_addsub(3, 2'b01, 2'b10, 8'h08);  // opcode flips to mul at c2, ignored
        mk_mul(4);
        mk_div(5, 1'b1);
        mk_div(6, 1'b0);
        // start held through DONE: one IDLE cycle then a new (sub) op
        add_vec(7, 1, 2'b00, 0, 0, 0, 8'h01, 0, 0);
        add_vec(7, 1, 2'b00, 0, 0, 0, 8'h02, 0, 1);
        add_vec(7, 1, 2'b00, 0, 0, 0, 8'h04, 0, 1);
        add_vec(7, 1, 2'b00, 0, 0, 0, 8'h20, 0, 1);
        add_vec(7, 1, 2'b00, 0, 0, 0, 8'h00, 1, 1);
        add_vec(7, 1, 2'b01, 0, 0, 0, 8'h01, 0, 0);
        add_vec(7, 1, 2'b01, 0, 0, 0, 8'h02, 0, 1);
        add_vec(7, 1, 2'b01, 0, 0, 0, 8'h08, 0, 1);
        add_vec(7, 1, 2'b01, 0, 0, 0, 8'h20, 0, 1);
        add_vec(7, 1, 2'b01, 0, 0, 0, 8'h00, 1, 1);
        add_vec(7, 0, 2'b01, 0, 0, 0, 8'h01, 0, 0);

        bus.start = 0; bus.opcode = 2'b00; bus.q0 = 0; bus.q_1 = 0; bus.a_msb = 0;

        // Reset state
        #12;
        check(0, 0, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a multiply (c7 = third MSHIFT)
        add_vec(8, 1, 2'b10, 0, 0, 0, 8'h01, 0, 0);
        add_vec(8, 1, 2'b10, 0, 0, 0, 8'h02, 0, 1);
        for (int i = 0; i < 3; i++) begin
            add_vec(8, 1, 2'b10, 0, 0, 0, 8'h00, 0, 1);
            add_vec(8, 1, 2'b10, 0, 0, 0, 8'h50, 0, 1);
        end
        for (int i = 0; i < 8; i++) begin
            v = tbl.pop_back();
            tbl.push_front(v);
        end
        for (int i = 0; i < 8; i++) begin
            v = tbl.pop_front();
            step(v, i);
        end
        rst = 1'b1;
        #1;
        check(8, 100, 8'h01, 1'b0, 1'b0);
        bus.start = 0;
        @(negedge clk);
        rst = 1'b0;
        v.tid = 9; v.start = 0; v.op = 2'b00; v.q0 = 0; v.q_1 = 0; v.a_msb = 0;
        v.cs = 8'h01; v.stop = 0; v.busy = 0;
        for (int i = 0; i < 25; i++) step(v, i);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
